// File: rtl/data_write_buffer_pkg.sv
// Shared types for the posted-store write buffer: entry layout and lane-mask helper.
// Optional forwarding is selected with the WBUF_FWD_EN macro (see data_write_buffer.sv).
package data_write_buffer_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BYTES  = DATA_W / 8;
  localparam int WORD_W = ADDR_W - 2;

  typedef struct packed {
    logic [WORD_W-1:0] word;
    logic [BYTES-1:0]  sel;
    logic [DATA_W-1:0] data;
  } wbuf_entry_t;

  function automatic logic [DATA_W-1:0] lane_mask(input logic [BYTES-1:0] sel);
    logic [DATA_W-1:0] m;
    m = '0;
    for (int b = 0; b < BYTES; b++) begin
      m[b*8 +: 8] = {8{sel[b]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/data_write_buffer_if.sv
// CPU data port, RAM port and flush/status signals of the write buffer.
// slave = buffer side, master = CPU/RAM side.
interface data_write_buffer_if
  import data_write_buffer_pkg::*;
#(
  parameter int DEPTH = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              cpu_cen;
  logic              cpu_wen;
  logic [ADDR_W-1:0] cpu_addr;
  logic [BYTES-1:0]  cpu_byte_sel;
  logic [DATA_W-1:0] cpu_sdata;
  logic [DATA_W-1:0] cpu_ldata;
  logic              cpu_stall;
  logic              flush;
  logic              empty;
  logic [CNT_W-1:0]  count;
  logic              ram_cen;
  logic              ram_wen;
  logic [ADDR_W-1:0] ram_addr;
  logic [BYTES-1:0]  ram_byte_sel;
  logic [DATA_W-1:0] ram_sdata;
  logic [DATA_W-1:0] ram_ldata;

  modport slave (
    input  cpu_cen, cpu_wen, cpu_addr, cpu_byte_sel, cpu_sdata, flush, ram_ldata,
    output cpu_ldata, cpu_stall, empty, count,
    output ram_cen, ram_wen, ram_addr, ram_byte_sel, ram_sdata
  );

  modport master (
    output cpu_cen, cpu_wen, cpu_addr, cpu_byte_sel, cpu_sdata, flush, ram_ldata,
    input  cpu_ldata, cpu_stall, empty, count,
    input  ram_cen, ram_wen, ram_addr, ram_byte_sel, ram_sdata
  );

endinterface

// File: rtl/data_write_buffer_match.sv
// Load-vs-pending-store hazard detection: per-entry hit vector and the youngest hit,
// found by walking backwards from the tail pointer.
module data_write_buffer_match
  import data_write_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  wbuf_entry_t       i_entries [DEPTH],
  input  logic [DEPTH-1:0]  i_valid,
  input  logic [WORD_W-1:0] i_word,
  input  logic [BYTES-1:0]  i_sel,
  input  logic [PTR_W-1:0]  i_tail,
  output logic [DEPTH-1:0]  o_hit_vec,
  output logic              o_any_hit,
  output logic [PTR_W-1:0]  o_young_idx,
  output logic              o_young_covers
);

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_hit
      assign o_hit_vec[gi] = i_valid[gi] && (i_entries[gi].word == i_word) &&
                             (|(i_entries[gi].sel & i_sel));
    end
  endgenerate

  assign o_any_hit = |o_hit_vec;

  // Oldest-to-youngest scan so the last assignment is the most recent store.
  always_comb begin
    o_young_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (o_hit_vec[i_tail - PTR_W'(i + 1)]) begin
        o_young_idx = i_tail - PTR_W'(i + 1);
      end
    end
  end

  assign o_young_covers = ((i_entries[o_young_idx].sel & i_sel) == i_sel);

endmodule

// File: rtl/data_write_buffer.sv
// Posted-store FIFO between the CPU data port and data RAM; loads bypass unless they hit.
// Define WBUF_FWD_EN to forward fully-covered load hits from the youngest pending store.
module data_write_buffer
  import data_write_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic               i_clk,
  input logic               i_rst,
  data_write_buffer_if.slave io_bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  wbuf_entry_t      r_entries [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  logic              w_load;
  logic              w_store;
  logic              w_full;
  logic              w_empty;
  logic              w_load_ram;
  logic              w_load_fwd;
  logic              w_enq;
  logic              w_drain;
  logic [DEPTH-1:0]  w_hit_vec;
  logic              w_any_hit;
  logic [PTR_W-1:0]  w_young_idx;
  logic              w_young_covers;
  logic [DATA_W-1:0] w_fwd_data;
  wbuf_entry_t       w_head_entry;

  data_write_buffer_match #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_match (
    .i_entries      (r_entries),
    .i_valid        (r_valid),
    .i_word         (io_bus.cpu_addr[ADDR_W-1:2]),
    .i_sel          (io_bus.cpu_byte_sel),
    .i_tail         (r_tail),
    .o_hit_vec      (w_hit_vec),
    .o_any_hit      (w_any_hit),
    .o_young_idx    (w_young_idx),
    .o_young_covers (w_young_covers)
  );

  assign w_load  = io_bus.cpu_cen & ~io_bus.cpu_wen;
  assign w_store = io_bus.cpu_cen &  io_bus.cpu_wen;
  // Registered count only: a drain in the same cycle does not free a slot for a store.
  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);

`ifdef WBUF_FWD_EN
  assign w_load_fwd = w_load & ~io_bus.flush & w_any_hit & w_young_covers;
  assign w_fwd_data = r_entries[w_young_idx].data & lane_mask(io_bus.cpu_byte_sel);
`else
  assign w_load_fwd = 1'b0;
  assign w_fwd_data = '0;
  logic w_unused_fwd;
  assign w_unused_fwd = &{1'b0, w_young_idx, w_young_covers, w_hit_vec};
`endif

  assign w_load_ram   = w_load & ~io_bus.flush & ~w_any_hit;
  assign w_enq        = w_store & ~w_full & ~io_bus.flush;
  assign w_drain      = ~w_load_ram & ~w_empty;
  assign w_head_entry = r_entries[r_head];

  always_comb begin
    io_bus.cpu_stall    = (w_store & (w_full | io_bus.flush)) |
                          (w_load & ~w_load_ram & ~w_load_fwd);
    io_bus.cpu_ldata    = '0;
    io_bus.ram_cen      = 1'b0;
    io_bus.ram_wen      = 1'b0;
    io_bus.ram_addr     = '0;
    io_bus.ram_byte_sel = '0;
    io_bus.ram_sdata    = '0;
    if (w_load_ram) begin
      io_bus.ram_cen      = 1'b1;
      io_bus.ram_addr     = io_bus.cpu_addr;
      io_bus.ram_byte_sel = io_bus.cpu_byte_sel;
      io_bus.cpu_ldata    = io_bus.ram_ldata;
    end else if (w_drain) begin
      io_bus.ram_cen      = 1'b1;
      io_bus.ram_wen      = 1'b1;
      io_bus.ram_addr     = {w_head_entry.word, 2'b00};
      io_bus.ram_byte_sel = w_head_entry.sel;
      io_bus.ram_sdata    = w_head_entry.data;
    end
    if (w_load_fwd) begin
      io_bus.cpu_ldata = w_fwd_data;
    end
  end

  assign io_bus.empty = w_empty;
  assign io_bus.count = r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= '0;
    end else begin
      if (w_enq) begin
        r_valid[r_tail] <= 1'b1;
        r_tail          <= r_tail + PTR_W'(1);
      end
      if (w_drain) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + PTR_W'(1);
      end
      r_count <= r_count + CNT_W'(w_enq) - CNT_W'(w_drain);
    end
  end

  // Payload needs no reset; r_valid and the pointers decide what is live.
  always_ff @(posedge i_clk) begin
    if (w_enq) begin
      r_entries[r_tail] <= '{word: io_bus.cpu_addr[ADDR_W-1:2],
                             sel:  io_bus.cpu_byte_sel,
                             data: io_bus.cpu_sdata};
    end
  end

endmodule

// File: tb/tb_data_write_buffer.sv
// Bench for data_write_buffer: queue-level reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_data_write_buffer;
  import data_write_buffer_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  data_write_buffer_if #(.DEPTH(DEPTH)) bus ();

  data_write_buffer #(.DEPTH(DEPTH)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (bus)
  );

  int n_checks = 0;
  int n_err    = 0;

  // RAM model driven by the DUT's RAM port
  logic [31:0] ram_mem [64];
  assign bus.ram_ldata = ram_mem[bus.ram_addr[7:2]];

  always @(posedge clk) begin
    if (bus.ram_cen && bus.ram_wen) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.ram_byte_sel[b]) ram_mem[bus.ram_addr[7:2]][b*8 +: 8] <= bus.ram_sdata[b*8 +: 8];
      end
    end
  end

  typedef struct {
    logic [29:0] word;
    logic [3:0]  sel;
    logic [31:0] data;
  } m_ent_t;

  m_ent_t      mq[$];
  logic [31:0] gmem [64];
  logic        d_enq   = 1'b0;
  logic        d_drain = 1'b0;
  m_ent_t      d_new;

  logic        m_load, m_store, m_hit, m_fwd, m_ramld, m_drain;
  m_ent_t      m_y;
  logic        e_stall, e_cen, e_wen;
  logic [31:0] e_ldata, e_addr, e_sdata;
  logic [3:0]  e_sel;

  function automatic logic [31:0] mask4(input logic [3:0] s);
    return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model evaluated on each falling edge
  always @(negedge clk) begin
    if (rst) begin
      d_enq   = 1'b0;
      d_drain = 1'b0;
    end else begin
      m_load  = bus.cpu_cen && !bus.cpu_wen;
      m_store = bus.cpu_cen && bus.cpu_wen;
      m_hit   = 1'b0;
      m_y     = '{word: '0, sel: '0, data: '0};
      if (m_load) begin
        foreach (mq[i]) begin
          if (mq[i].word == bus.cpu_addr[31:2] && (mq[i].sel & bus.cpu_byte_sel) != 4'h0) begin
            m_hit = 1'b1;
            m_y   = mq[i];
          end
        end
      end
      m_fwd = 1'b0;
`ifdef WBUF_FWD_EN
      m_fwd = m_load && !bus.flush && m_hit && ((m_y.sel & bus.cpu_byte_sel) == bus.cpu_byte_sel);
`endif
      m_ramld = m_load && !bus.flush && !m_hit;
      e_stall = (m_store && (mq.size() == DEPTH || bus.flush)) || (m_load && !m_ramld && !m_fwd);
      m_drain = !m_ramld && (mq.size() > 0);
      e_ldata = m_ramld ? gmem[bus.cpu_addr[7:2]] : (m_fwd ? (m_y.data & mask4(bus.cpu_byte_sel)) : 32'h0);
      e_cen = 1'b0; e_wen = 1'b0; e_addr = '0; e_sel = '0; e_sdata = '0;
      if (m_ramld) begin
        e_cen = 1'b1; e_addr = bus.cpu_addr; e_sel = bus.cpu_byte_sel;
      end else if (m_drain) begin
        e_cen = 1'b1; e_wen = 1'b1; e_addr = {mq[0].word, 2'b00}; e_sel = mq[0].sel; e_sdata = mq[0].data;
      end
      chk("cpu_stall",    32'(bus.cpu_stall),    32'(e_stall));
      chk("cpu_ldata",    bus.cpu_ldata,         e_ldata);
      chk("ram_cen",      32'(bus.ram_cen),      32'(e_cen));
      chk("ram_wen",      32'(bus.ram_wen),      32'(e_wen));
      chk("ram_addr",     bus.ram_addr,          e_addr);
      chk("ram_byte_sel", 32'(bus.ram_byte_sel), 32'(e_sel));
      chk("ram_sdata",    bus.ram_sdata,         e_sdata);
      chk("count",        32'(bus.count),        32'(mq.size()));
      chk("empty",        32'(bus.empty),        32'(mq.size() == 0));
      d_enq   = m_store && !e_stall;
      d_drain = m_drain;
      d_new   = '{word: bus.cpu_addr[31:2], sel: bus.cpu_byte_sel, data: bus.cpu_sdata};
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
    end else begin
      if (d_drain) begin
        for (int b = 0; b < 4; b++) begin
          if (mq[0].sel[b]) gmem[mq[0].word[5:0]][b*8 +: 8] <= mq[0].data[b*8 +: 8];
        end
        void'(mq.pop_front());
      end
      if (d_enq) mq.push_back(d_new);
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) sync();
  endtask

  task automatic req(input logic wen, input logic [31:0] addr, input logic [3:0] sel,
                     input logic [31:0] data, output int stalls, output logic [31:0] ldata);
    logic st;
    logic acc;
    bus.cpu_cen = 1'b1; bus.cpu_wen = wen; bus.cpu_addr = addr;
    bus.cpu_byte_sel = sel; bus.cpu_sdata = data;
    stalls = 0; ldata = '0; acc = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      st    = bus.cpu_stall;
      ldata = bus.cpu_ldata;
      sync();
      if (!st) begin
        acc = 1'b1;
        break;
      end
      stalls++;
    end
    chk("accept_timeout", 32'(acc), 32'd1);
    bus.cpu_cen = 1'b0; bus.cpu_wen = 1'b0; bus.cpu_addr = '0;
    bus.cpu_byte_sel = '0; bus.cpu_sdata = '0;
    $display("txn %s addr=%h sel=%h sdata=%h ldata=%h stalls=%0d",
             wen ? "ST" : "LD", addr, sel, data, ldata, stalls);
  endtask

  int          ns;
  logic [31:0] ld;
  logic        st_s, em_s;

  initial begin
    for (int i = 0; i < 64; i++) begin
      ram_mem[i] = '0;
      gmem[i]    = '0;
    end
    bus.cpu_cen = 1'b0; bus.cpu_wen = 1'b0; bus.cpu_addr = '0;
    bus.cpu_byte_sel = '0; bus.cpu_sdata = '0; bus.flush = 1'b0;

    // reset state
    @(negedge clk);
    chk("rst_empty", 32'(bus.empty),     32'd1);
    chk("rst_stall", 32'(bus.cpu_stall), 32'd0);
    chk("rst_cen",   32'(bus.ram_cen),   32'd0);
    chk("rst_ldata", bus.cpu_ldata,      32'd0);
    chk("rst_count", 32'(bus.count),     32'd0);
    @(posedge clk); #1; rst = 1'b0;
    idle(1);

    // single store drains next cycle
    req(1'b1, 32'h10, 4'hF, 32'hAABBCCDD, ns, ld);
    @(negedge clk);
    chk("t1_wen",   32'(bus.ram_wen),      32'd1);
    chk("t1_addr",  bus.ram_addr,          32'h10);
    chk("t1_sel",   32'(bus.ram_byte_sel), 32'hF);
    chk("t1_sdata", bus.ram_sdata,         32'hAABBCCDD);
    sync();
    @(negedge clk);
    chk("t1_empty", 32'(bus.empty), 32'd1);
    sync();

    // five back-to-back stores, tail wraps
    for (int i = 0; i < 5; i++) begin
      req(1'b1, 32'h24 + 32'(4 * i), 4'hF, 32'hD0000001 + 32'(i), ns, ld);
      chk("t2_stall", 32'(ns), 32'd0);
    end
    idle(3);
    chk("t2_mem24", ram_mem[9],  32'hD0000001);
    chk("t2_mem34", ram_mem[13], 32'hD0000005);

    // store then load to the same word
    req(1'b1, 32'h20, 4'hF, 32'h11223344, ns, ld);
    req(1'b0, 32'h20, 4'hF, 32'h0, ns, ld);
    chk("t3_ldata", ld, 32'h11223344);
`ifdef WBUF_FWD_EN
    chk("t3_stall", 32'(ns), 32'd0);
`else
    chk("t3_stall", 32'(ns), 32'd1);
`endif
    idle(2);

    // disjoint lanes and different word: no hazard
    req(1'b1, 32'h20, 4'h1, 32'h000000EE, ns, ld);
    req(1'b0, 32'h20, 4'hC, 32'h0, ns, ld);
    chk("t4_stall", 32'(ns), 32'd0);
    chk("t4_ldata", ld, 32'h11223344);
    req(1'b1, 32'h20, 4'h1, 32'h00000055, ns, ld);
    req(1'b0, 32'h24, 4'hF, 32'h0, ns, ld);
    chk("t4b_stall", 32'(ns), 32'd0);
    chk("t4b_ldata", ld, 32'hD0000001);
    idle(2);

    // partial coverage always stalls; full coverage may forward
    req(1'b1, 32'h40, 4'h3, 32'h0000BEEF, ns, ld);
    req(1'b0, 32'h40, 4'hF, 32'h0, ns, ld);
    chk("t3b_stall", 32'(ns), 32'd1);
    chk("t3b_ldata", ld, 32'h0000BEEF);
    req(1'b1, 32'h44, 4'hF, 32'hCAFEF00D, ns, ld);
    req(1'b0, 32'h44, 4'h6, 32'h0, ns, ld);
`ifdef WBUF_FWD_EN
    chk("t3c_stall", 32'(ns), 32'd0);
    chk("t3c_ldata", ld, 32'h00FEF000);
`else
    chk("t3c_stall", 32'(ns), 32'd1);
    chk("t3c_ldata", ld, 32'hCAFEF00D);
`endif
    idle(2);

    // flush holds off a store until the buffer is empty
    req(1'b1, 32'h50, 4'hF, 32'h00000005, ns, ld);
    bus.flush = 1'b1;
    bus.cpu_cen = 1'b1; bus.cpu_wen = 1'b1; bus.cpu_addr = 32'h54;
    bus.cpu_byte_sel = 4'hF; bus.cpu_sdata = 32'h00000006;
    ns = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      st_s = bus.cpu_stall;
      em_s = bus.empty;
      sync();
      if (em_s) bus.flush = 1'b0;
      if (!st_s) break;
      ns++;
    end
    chk("t5_stalls", 32'(ns), 32'd2);
    bus.cpu_cen = 1'b0; bus.cpu_wen = 1'b0; bus.cpu_addr = '0;
    bus.cpu_byte_sel = '0; bus.cpu_sdata = '0; bus.flush = 1'b0;
    $display("txn ST(flush) addr=00000054 stalls=%0d", ns);

    // reset discards the pending store
    #1; rst = 1'b1;
    @(negedge clk);
    chk("t6_count", 32'(bus.count),   32'd0);
    chk("t6_empty", 32'(bus.empty),   32'd1);
    chk("t6_cen",   32'(bus.ram_cen), 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    idle(3);
    chk("t6_mem54",   ram_mem[21],     32'h0);
    chk("t6_count_b", 32'(bus.count),  32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
